// File: rtl/mulu_seq_ctrl.sv
// Sequencing controller: wide unsigned X*Y computed one 2-bit digit pair per clock on an external 2x2 multiplier.
// Optional macro MULU_SEQ_EARLY_EXIT_EN stops the run once the remaining y digits are all zero.
module mulu_seq_ctrl #(
  parameter int N_WIDTH = 8,
  parameter int M_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_WIDTH-1:0]           x,
  input  logic [M_WIDTH-1:0]           y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_WIDTH+M_WIDTH-1:0]   p,
  output logic [1:0]                   mul_x,
  output logic [1:0]                   mul_y,
  input  logic [3:0]                   mul_p
);

  localparam int ND = N_WIDTH / 2;
  localparam int MD = M_WIDTH / 2;
  localparam int P  = N_WIDTH + M_WIDTH;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int JW = (MD > 1) ? $clog2(MD) : 1;
  localparam int SW = $clog2(P) + 1;
  localparam logic [IW-1:0] I_LAST = IW'(ND - 1);
  localparam logic [JW-1:0] J_LAST = JW'(MD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [P-1:0]        acc_r, acc_s;
  logic [N_WIDTH-1:0]  x_r, x_s;
  logic [M_WIDTH-1:0]  y_r, y_s;
  logic [IW-1:0]       i_r, i_s;
  logic [JW-1:0]       j_r, j_s;
  logic [1:0]          mul_x_r, mul_x_s;
  logic [1:0]          mul_y_r, mul_y_s;
  logic                in_ready_r, in_ready_s;
  logic                out_valid_r, out_valid_s;
  logic [SW:0]         sh_s;
`ifdef MULU_SEQ_EARLY_EXIT_EN
  logic [M_WIDTH-1:0]  y_rest_s;
`endif

  // Digit k (2 bits) of a vector, zero once k runs past the top.
  function automatic logic [1:0] digit_at(input logic [P-1:0] v, input logic [SW-1:0] k);
    return 2'(v >> {k, 1'b0});
  endfunction

  // Next-state, accumulator and next multiplier-digit selection.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    x_s      = x_r;
    y_s      = y_r;
    i_s      = i_r;
    j_s      = j_r;
    mul_x_s  = 2'b00;
    mul_y_s  = 2'b00;
    sh_s     = {SW'(i_r) + SW'(j_r), 1'b0};
`ifdef MULU_SEQ_EARLY_EXIT_EN
    y_rest_s = y_r >> {SW'(j_r) + SW'(1), 1'b0};
`endif
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          x_s     = x;
          y_s     = y;
          acc_s   = '0;
          i_s     = '0;
          j_s     = '0;
          state_s = RUN;
`ifdef MULU_SEQ_EARLY_EXIT_EN
          if (y == '0) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s = acc_r + (P'(mul_p) << sh_s);
        if (i_r == I_LAST) begin
          i_s = '0;
          if (j_r == J_LAST) begin
            state_s = DONE;
          end else begin
            j_s = j_r + JW'(1);
`ifdef MULU_SEQ_EARLY_EXIT_EN
            if (y_rest_s == '0) begin
              state_s = DONE;
            end else begin
              state_s = RUN;
            end
`endif
          end
        end else begin
          i_s = i_r + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = '0;
        i_s     = '0;
        j_s     = '0;
      end
    endcase
    // Digits are registered so they line up with the counters of the cycle they serve.
    if (state_s == RUN) begin
      mul_x_s = digit_at(P'(x_s), SW'(i_s));
      mul_y_s = digit_at(P'(y_s), SW'(j_s));
    end else begin
      mul_x_s = 2'b00;
      mul_y_s = 2'b00;
    end
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      x_r         <= '0;
      y_r         <= '0;
      i_r         <= '0;
      j_r         <= '0;
      mul_x_r     <= 2'b00;
      mul_y_r     <= 2'b00;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      x_r         <= x_s;
      y_r         <= y_s;
      i_r         <= i_s;
      j_r         <= j_s;
      mul_x_r     <= mul_x_s;
      mul_y_r     <= mul_y_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign p         = acc_r;
  assign mul_x     = mul_x_r;
  assign mul_y     = mul_y_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mulu_seq_ctrl.sv
// Self-checking bench for mulu_seq_ctrl: directed cases plus randomized ops against an arithmetic reference.
// Honours MULU_SEQ_EARLY_EXIT_EN when computing expected latency.
module tb_mulu_seq_ctrl;

  localparam int N  = 8;
  localparam int M  = 8;
  localparam int ND = N / 2;
  localparam int MD = M / 2;
  localparam int P  = N + M;
  localparam int LIMIT = ND * MD + 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [M-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] p;
  logic [1:0]   mul_x;
  logic [1:0]   mul_y;
  logic [3:0]   mul_p;

  int n_checks = 0;
  int n_fail   = 0;

  mulu_seq_ctrl #(.N_WIDTH(N), .M_WIDTH(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p)
  );

  // The shared 2x2 multiplier.
  assign mul_p = {2'b00, mul_x} * {2'b00, mul_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] dig(input logic [63:0] v, input int k);
    return 2'(v >> (2 * k));
  endfunction

  // Edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input logic [M-1:0] v);
`ifdef MULU_SEQ_EARLY_EXIT_EN
    if (v == '0) return 0;
    for (int k = MD - 1; k >= 0; k--) begin
      if (dig(64'(v), k) != 2'b00) return ND * (k + 1);
    end
    return 0;
`else
    return ND * MD;
`endif
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [N-1:0] xa, input logic [M-1:0] ya, input int stall);
    int c;
    int bad;
    int el;
    logic [P-1:0] expp;
    expp = P'(xa) * P'(ya);
    el   = exp_lat(ya);
    wait_idle();
    in_valid = 1'b1;
    x = xa;
    y = ya;
    @(negedge clk);
    in_valid = 1'b0;
    x = N'($urandom);
    y = M'($urandom);
    c = 0;
    bad = 0;
    while (out_valid !== 1'b1 && c < LIMIT) begin
      if (mul_x !== dig(64'(xa), c % ND) || mul_y !== dig(64'(ya), c / ND) || in_ready !== 1'b0) bad++;
      @(negedge clk);
      c++;
    end
    check("latency", 64'(c), 64'(el));
    check("product", 64'(p), 64'(expp));
    check("run_digits", 64'(bad), 64'd0);
    check("done_mul_idle", {60'd0, mul_x, mul_y}, 64'd0);
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      x = N'($urandom);
      y = M'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || p !== expp || in_ready !== 1'b0 || mul_x !== 2'b00 || mul_y !== 2'b00) bad++;
    end
    if (stall > 0) check("stall_hold", 64'(bad), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released", {60'd0, out_valid, in_ready, mul_x}, {60'd0, 1'b0, 1'b1, 2'b00});
    check("p_kept", 64'(p), 64'(expp));
  endtask

  initial begin
    logic [N-1:0] rx;
    logic [M-1:0] ry;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    repeat (2) @(negedge clk);
    check("rst_p", 64'(p), 64'd0);
    check("rst_flags", {60'd0, out_valid, mul_x, mul_y[0]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'hAB, 1);
    run_op(8'hFF, 8'h03, 0);
    run_op(8'h12, 8'h00, 2);
    run_op(8'h0D, 8'hB7, 5);

    // Reset in the middle of a run discards the product.
    wait_idle();
    in_valid = 1'b1;
    x = 8'hA5;
    y = 8'h5A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_p", 64'(p), 64'd0);
    check("midrun_rst_flags", {60'd0, out_valid, in_ready, mul_x}, {60'd0, 1'b0, 1'b1, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h03, 8'h03, 0);

    for (int n = 0; n < 1000; n++) begin
      rx = N'($urandom);
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = M'($urandom_range(0, 15));
        default: ry = M'($urandom);
      endcase
      run_op(rx, ry, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
